// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streaming AES AddRoundKey stage with a registered round-key bank
//
// Parameters:
//   DATA_W   - beat width (32, 64 or 128); a 128-bit state is BEATS = 128/DATA_W beats
//   NUM_KEYS - round-key bank depth (11/13/15 for AES-128/192/256)
//   KIDX_W   - key index width, derived from NUM_KEYS
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   key_wr_en/key_wr_idx/key_wr_data  - bank write (out-of-range indices ignored)
//   s_valid/s_ready/s_data/s_round    - input beat stream; s_round sampled on beat 0
//   m_valid/m_ready/m_data/m_last     - registered output stream
//   err_round/err_clr                 - sticky out-of-range round flag and its clear
// Optional feature macro: ARK_RANGE_CHECK_EN (round index range check and err_round)
module add_round_key_stream #(
    parameter int DATA_W = 128,
    parameter int NUM_KEYS = 11,
    localparam int KIDX_W = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_wr_en,
    input  logic [KIDX_W-1:0] key_wr_idx,
    input  logic [127:0]      key_wr_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KIDX_W-1:0] s_round,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              err_round,
    input  logic              err_clr
);
    localparam int BEATS = 128 / DATA_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

    logic [127:0]      bank_q [NUM_KEYS];
    logic [127:0]      key_hold_q, key_hold_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic [127:0]      bank_key, lookup, key0, key_cur;
    logic [DATA_W-1:0] slice;
    logic              accept, beat0, last_beat;

    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign beat0     = beat_q == '0;
    assign last_beat = beat_q == BW'(BEATS - 1);
    // Same-cycle write to the looked-up entry is forwarded so a freshly written key is usable at once
    assign lookup    = (key_wr_en && key_wr_idx == s_round) ? key_wr_data : bank_key;

    always_comb begin
        bank_key = '0;
        for (int i = 0; i < NUM_KEYS; i++) if (s_round == KIDX_W'(i)) bank_key = bank_q[i];
        key_cur = beat0 ? key0 : key_hold_q;
        // Beat b uses key bits [127-b*DATA_W -: DATA_W]
        slice = DATA_W'(key_cur >> (128 - DATA_W * (int'(beat_q) + 1)));
        beat_d = accept ? (last_beat ? '0 : beat_q + 1'b1) : beat_q;
        m_valid_d = accept || (m_valid_q && !m_ready);
        m_data_d = accept ? s_data ^ slice : m_data_q;
        m_last_d = accept ? last_beat : m_last_q;
        key_hold_d = (accept && beat0) ? key0 : key_hold_q;
    end

`ifdef ARK_RANGE_CHECK_EN
    localparam logic [KIDX_W:0] NK = NUM_KEYS[KIDX_W:0];
    logic round_bad, err_q, err_d;
    assign round_bad = {1'b0, s_round} >= NK;
    assign key0      = round_bad ? '0 : lookup;
    // Set wins over a simultaneous clear
    assign err_d     = (accept && beat0 && round_bad) || (err_q && !err_clr);
    assign err_round = err_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_q <= 1'b0;
        else err_q <= err_d;
`else
    assign key0      = lookup;
    assign err_round = err_clr & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) bank_q[i] <= '0;
            key_hold_q <= '0;
            beat_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) if (key_wr_en && key_wr_idx == KIDX_W'(i)) bank_q[i] <= key_wr_data;
            key_hold_q <= key_hold_d;
            beat_q <= beat_d;
            m_valid_q <= m_valid_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
endmodule

// File: tb/tb_add_round_key_stream.sv
// tb_add_round_key_stream: directed vector bench for add_round_key_stream (DATA_W=32 and DATA_W=128 instances)
module tb_add_round_key_stream;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY1 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         kw_en, s_valid, s_ready, m_valid, m_ready, m_last, err_round, err_clr;
    logic [3:0]   kw_idx, s_round;
    logic [127:0] kw_data;
    logic [31:0]  s_data, m_data;

    logic         w_en, v_valid, v_ready, n_valid, n_last, n_err;
    logic [127:0] v_data, n_data;

    add_round_key_stream #(.DATA_W(32), .NUM_KEYS(11)) u32 (
        .clk(clk), .rst_n(rst_n), .key_wr_en(kw_en), .key_wr_idx(kw_idx), .key_wr_data(kw_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_round(s_round),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .err_round(err_round), .err_clr(err_clr)
    );

    add_round_key_stream #(.DATA_W(128), .NUM_KEYS(11)) u128 (
        .clk(clk), .rst_n(rst_n), .key_wr_en(w_en), .key_wr_idx(4'd0), .key_wr_data(KEY0),
        .s_valid(v_valid), .s_ready(v_ready), .s_data(v_data), .s_round(4'd0),
        .m_valid(n_valid), .m_ready(1'b1), .m_data(n_data), .m_last(n_last),
        .err_round(n_err), .err_clr(1'b0)
    );

    typedef struct {
        logic [31:0] din;
        logic [3:0]  rnd;
        logic [31:0] exp;
        logic        last;
    } vec_t;
    vec_t tbl[8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string name, input logic [31:0] d, input logic [3:0] r,
                        input logic [31:0] exp, input logic last);
        s_valid = 1'b1;
        s_data = d;
        s_round = r;
        tick();
        chk({name, ".valid"}, 128'(m_valid), 128'(1'b1));
        chk({name, ".data"}, 128'(m_data), 128'(exp));
        chk({name, ".last"}, 128'(m_last), 128'(last));
    endtask

    initial begin
        tbl[0] = '{32'h00112233, 4'd0, 32'h00102030, 1'b0};
        tbl[1] = '{32'h44556677, 4'd7, 32'h40506070, 1'b0};
        tbl[2] = '{32'h8899aabb, 4'd7, 32'h8090a0b0, 1'b0};
        tbl[3] = '{32'hccddeeff, 4'd7, 32'hc0d0e0f0, 1'b1};
        tbl[4] = '{32'h00112233, 4'd1, 32'h11003322, 1'b0};
        tbl[5] = '{32'h44556677, 4'd0, 32'h66774455, 1'b0};
        tbl[6] = '{32'h8899aabb, 4'd0, 32'hbbaa9988, 1'b0};
        tbl[7] = '{32'hccddeeff, 4'd0, 32'h8899aabb, 1'b1};
        kw_en = 0; kw_idx = 0; kw_data = 0; s_valid = 0; s_data = 0; s_round = 0;
        m_ready = 1; err_clr = 0; w_en = 0; v_valid = 0; v_data = 0;
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #1;
        chk("rst.m_valid", 128'(m_valid), 128'(1'b0));
        chk("rst.m_data", 128'(m_data), 128'(0));
        chk("rst.m_last", 128'(m_last), 128'(1'b0));
        chk("rst.s_ready", 128'(s_ready), 128'(1'b1));
        chk("rst.err", 128'(err_round), 128'(1'b0));
        chk("rst.n_valid", 128'(n_valid), 128'(1'b0));
        tick();
        kw_en = 1; kw_idx = 0; kw_data = KEY0;
        tick();
        kw_idx = 1; kw_data = KEY1;
        tick();
        kw_en = 0;
        for (int i = 0; i < 8; i++) beat($sformatf("tbl%0d", i), tbl[i].din, tbl[i].rnd, tbl[i].exp, tbl[i].last);
        s_valid = 0;
        tick();
        chk("idle.m_valid", 128'(m_valid), 128'(1'b0));

        w_en = 1; v_valid = 1; v_data = PT;
        tick();
        w_en = 0; v_valid = 0;
        chk("fips.valid", 128'(n_valid), 128'(1'b1));
        chk("fips.data", n_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("fips.last", 128'(n_last), 128'(1'b1));
        tick();
        chk("fips.drain", 128'(n_valid), 128'(1'b0));

        beat("bp0", 32'h00112233, 4'd0, 32'h00102030, 1'b0);
        beat("bp1", 32'h44556677, 4'd0, 32'h40506070, 1'b0);
        m_ready = 0;
        s_data = 32'h8899aabb;
        #1;
        chk("bp.s_ready", 128'(s_ready), 128'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp.hold%0d.valid", i), 128'(m_valid), 128'(1'b1));
            chk($sformatf("bp.hold%0d.data", i), 128'(m_data), 128'(32'h40506070));
            chk($sformatf("bp.hold%0d.last", i), 128'(m_last), 128'(1'b0));
            chk($sformatf("bp.hold%0d.s_ready", i), 128'(s_ready), 128'(1'b0));
        end
        m_ready = 1;
        #1;
        chk("bp.release.s_ready", 128'(s_ready), 128'(1'b1));
        beat("bp2", 32'h8899aabb, 4'd0, 32'h8090a0b0, 1'b0);
        beat("bp3", 32'hccddeeff, 4'd0, 32'hc0d0e0f0, 1'b1);
        s_valid = 0;
        tick();
        chk("bp.drain", 128'(m_valid), 128'(1'b0));

        beat("snap0", 32'h00112233, 4'd0, 32'h00102030, 1'b0);
        beat("snap1", 32'h44556677, 4'd0, 32'h40506070, 1'b0);
        s_valid = 0;
        kw_en = 1; kw_idx = 0; kw_data = '1;
        tick();
        kw_en = 0;
        beat("snap2", 32'h8899aabb, 4'd0, 32'h8090a0b0, 1'b0);
        beat("snap3", 32'hccddeeff, 4'd0, 32'hc0d0e0f0, 1'b1);
        beat("new0", 32'h00112233, 4'd0, 32'hffeeddcc, 1'b0);
        beat("new1", 32'h44556677, 4'd0, 32'hbbaa9988, 1'b0);
        beat("new2", 32'h8899aabb, 4'd0, 32'h77665544, 1'b0);
        s_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.m_valid", 128'(m_valid), 128'(1'b0));
        chk("arst.m_data", 128'(m_data), 128'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        kw_en = 1; kw_idx = 0; kw_data = KEY0;
        tick();
        kw_en = 0;
        beat("post0", 32'h00112233, 4'd0, 32'h00102030, 1'b0);
        beat("post1", 32'h44556677, 4'd0, 32'h40506070, 1'b0);
        beat("post2", 32'h8899aabb, 4'd0, 32'h8090a0b0, 1'b0);
        beat("post3", 32'hccddeeff, 4'd0, 32'hc0d0e0f0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            s_valid = 1;
            s_data = PT[127 - 32*i -: 32];
            s_round = (i == 0) ? 4'd11 : 4'd0;
            tick();
            chk($sformatf("rng%0d.valid", i), 128'(m_valid), 128'(1'b1));
            chk($sformatf("rng%0d.last", i), 128'(m_last), 128'(i == 3));
`ifdef ARK_RANGE_CHECK_EN
            chk($sformatf("rng%0d.data", i), 128'(m_data), 128'(PT[127 - 32*i -: 32]));
            chk($sformatf("rng%0d.err", i), 128'(err_round), 128'(1'b1));
`else
            chk($sformatf("rng%0d.err", i), 128'(err_round), 128'(1'b0));
`endif
        end
        s_valid = 0;
        tick();
`ifdef ARK_RANGE_CHECK_EN
        chk("rng.sticky", 128'(err_round), 128'(1'b1));
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("rng.clr", 128'(err_round), 128'(1'b0));
`else
        chk("rng.off", 128'(err_round), 128'(1'b0));
`endif
        chk("end.m_valid", 128'(m_valid), 128'(1'b0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_round_key_stream.md
# add_round_key_stream

Streaming, parametrised AddRoundKey stage for the AES datapath. It holds a round-key bank of `NUM_KEYS` 128-bit entries, loaded by the key expansion logic. It accepts a 128-bit state as `BEATS = 128/DATA_W` beats on a valid/ready stream and XORs each beat with the matching slice of the selected round key. The result is presented one cycle later on a registered output stream. It sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the round controller, replacing the purely combinational 128-bit XOR stage.

## Interface
- `DATA_W`, 128 — beat width; legal 32, 64, 128.
- `NUM_KEYS`, 11 — round-key bank depth; 11/13/15 for AES-128/192/256.
- `KIDX_W`, `$clog2(NUM_KEYS)` — key index width (derived, not overridden).
- `clk` in 1 — sole clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `key_wr_en` in 1 — write `key_wr_data` into bank entry `key_wr_idx`.
- `key_wr_idx` in KIDX_W — bank write index.
- `key_wr_data` in 128 — round key, byte 0 at bits [127:120].
- `s_valid` in 1 — input beat valid.
- `s_ready` out 1 — input beat accepted when `s_valid && s_ready`.
- `s_data` in DATA_W — state beat, MSB-first (beat 0 = bits [127:128-DATA_W]).
- `s_round` in KIDX_W — round index; sampled on beat 0 only.
- `m_valid` out 1 — output beat valid.
- `m_ready` in 1 — downstream accepts.
- `m_data` out DATA_W — `s_data ^ key slice`.
- `m_last` out 1 — marks the final beat of a block.
- `err_round` out 1 — sticky out-of-range round flag (see Configuration).
- `err_clr` in 1 — synchronous clear of `err_round`.

## Operation
- Key bank: `NUM_KEYS` x 128 flops. All entries reset to 0. Written on any cycle with `key_wr_en`; writes with `key_wr_idx >= NUM_KEYS` are ignored.
- Beat counter `beat`, 0..BEATS-1: increments on each accepted input beat and wraps to 0 after BEATS-1. When BEATS = 1, every beat is beat 0 and `m_last` is always 1.
- Beat 0 handling:
  - Key = bank[s_round]. If `key_wr_en` targets the same index in the same cycle, `key_wr_data` is used (write bypass).
  - The full 128-bit key is snapshotted into `key_hold`.
- Beats 1..BEATS-1 use `key_hold`. Bank writes during a block never affect that block.
- Slice for beat b: key bits [127-b·DATA_W -: DATA_W].
- Output register: `m_data`, `m_valid`, `m_last` are loaded on accept.
- `s_ready = !m_valid || m_ready`. This gives full throughput with no bubble when `m_ready` is held high.
- Hold rule: while `m_valid && !m_ready`, `m_data` and `m_last` stay stable and `s_ready` = 0.
- `err_clr` and a new error in the same cycle: the flag is set (set wins).

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `err_round`=0, `beat`=0, `key_hold`=0, bank=0. `s_ready`=1 out of reset (combinational).
- Latency: an input accepted at edge N gives `m_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle; one 128-bit block per BEATS cycles.
- A key written at edge N is usable by a block whose beat 0 is accepted at edge N (bypass) or later.
- Reset mid-block: asynchronous clear of all state. The partial block is dropped and the next accepted beat is beat 0.

## Configuration
- `ARK_RANGE_CHECK_EN` defined:
  - Beat 0 with `s_round >= NUM_KEYS` uses an all-zero key for the whole block; the data passes through unchanged.
  - `err_round` sets on the cycle after the accept and holds until `err_clr`.
- `ARK_RANGE_CHECK_EN` undefined:
  - No range compare logic.
  - `err_round` is tied to 0.
  - The key used for an out-of-range index is unspecified; the bench must not check it.

## Test plan
- FIPS-197 vector, DATA_W=128: key0=000102030405060708090a0b0c0d0e0f, s_data=00112233445566778899aabbccddeeff, round 0 -> m_data=00102030405060708090a0b0c0d0e0f0, m_last=1, one cycle after accept.
- DATA_W=32, same vector streamed over 4 beats with m_ready=1 -> beats 00102030, 40506070, 8090a0b0, c0d0e0f0 on consecutive cycles; m_last only on the 4th.
- Backpressure, DATA_W=32: m_ready=0 for 3 cycles after beat 1 -> s_ready=0 and m_data held at 40506070; release -> remaining beats correct, no loss or duplication.
- Key snapshot: rewrite entry 0 to all-ones between beats 1 and 2 -> the current block is unchanged; the next block uses the new key (beat 0 = ffeeddcc for input 00112233).
- Range check (macro on): s_round=11, NUM_KEYS=11 -> m_data == s_data and err_round=1; err_clr -> err_round=0 next cycle.
- Assert rst_n low mid-block after beat 2 -> m_valid=0 at once; after release, the first beat is treated as beat 0 with a fresh key lookup.
